fab_int_sched: RTL and testbench

//  Shares the single fabric-to-MSS interrupt line (FABINT) among N fabric event sources (timer

---
 rtl/fab_int_pkg.sv | 14 +
 rtl/fab_int_rr_arb.sv | 29 ++
 rtl/fab_int_sched.sv | 138 +++++++++++++
 tb/tb_fab_int_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fab_int_pkg.sv
// Shared types and default constants for the fabric interrupt scheduler.
package fab_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int unsigned DEF_N_SRC       = 4;
    localparam int unsigned DEF_HOLDOFF_CYC = 8;
    localparam int unsigned DEF_ACK_TIMEOUT = 1024;

endpackage

// File: rtl/fab_int_rr_arb.sv
// Combinational round-robin pick: first set request above ptr, wrapping.
module fab_int_rr_arb
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] grant,
    output logic             valid
);

    logic [SRC_W-1:0] idx;

    // Walk from the farthest offset down so the nearest match is assigned last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = int'(N_SRC); k > 0; k--) begin
            idx = SRC_W'((int'(ptr) + k) % int'(N_SRC));
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fab_int_sched.sv
// Shares the single FABINT line among N_SRC fabric event sources, round-robin with ack holdoff.
// Optional ack timeout with forced release and retry: define FAB_INT_TIMEOUT_EN.
module fab_int_sched
    import fab_int_pkg::*;
#(
    parameter int unsigned N_SRC       = DEF_N_SRC,
    parameter int unsigned SRC_W       = $clog2(N_SRC),
    parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_req,
    input  logic [N_SRC-1:0] src_en,
    input  logic             int_ack,
    input  logic             clr_overrun,
    output logic             FAB_INT_OUT,
    output logic [SRC_W-1:0] int_src,
    output logic             int_busy,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun,
    output logic             timeout_err
);

    localparam int unsigned HOLD_W    = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam int unsigned HOLD_LAST = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;

    if (N_SRC < 2 || N_SRC > 16 || ACK_TIMEOUT == 0) begin : g_bad_param
        $error("fab_int_sched: unsupported parameter set");
    end

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  int_src_d;
    logic              int_out_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_SRC-1:0]  pend_clr, pend_retry;
    logic [SRC_W-1:0]  grant;
    logic              grant_vld;
    logic              tmo_expire;

    fab_int_rr_arb #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_arb (
        .req   (pending),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_vld)
    );

    // Next-state and next-output logic; ack takes priority over timeout expiry.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        int_src_d  = int_src;
        int_out_d  = FAB_INT_OUT;
        hold_cnt_d = hold_cnt_q;
        pend_clr   = '0;
        pend_retry = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d         = ST_ASSERT;
                    int_src_d       = grant;
                    rr_ptr_d        = grant;
                    int_out_d       = 1'b1;
                    pend_clr[grant] = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (int_ack || tmo_expire) begin
                    int_out_d  = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = (HOLDOFF_CYC == 0) ? ST_IDLE : ST_HOLDOFF;
                    if (!int_ack) begin
                        pend_retry[int_src] = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == HOLD_W'(HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // New events win over grant-clear and clr_overrun in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= SRC_W'(N_SRC - 1);
            hold_cnt_q  <= '0;
            FAB_INT_OUT <= 1'b0;
            int_src     <= '0;
            int_busy    <= 1'b0;
            pending     <= '0;
            overrun     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            FAB_INT_OUT <= int_out_d;
            int_src     <= int_src_d;
            int_busy    <= (state_d != ST_IDLE);
            pending     <= (pending & ~pend_clr) | pend_retry | (src_req & src_en);
            overrun     <= (clr_overrun ? '0 : overrun) | (src_req & pending);
        end
    end

`ifdef FAB_INT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_expire = (state_q == ST_ASSERT) && (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1));

    // Counts cycles spent in ASSERT; restarts on every new grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_expire && !int_ack;
            if (state_q == ST_ASSERT && state_d == ST_ASSERT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end
`else
    assign tmo_expire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fab_int_sched.sv
// Directed bench for fab_int_sched: vector table plus hand sequences (HOLDOFF_CYC 8 and 0 instances).
module tb_fab_int_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] src_req, src_en;
    logic       int_ack, clr_overrun;

    logic       d_out, z_out, d_busy, z_busy, d_terr, z_terr;
    logic [1:0] d_src, z_src;
    logic [3:0] d_pend, z_pend, d_ovr, z_ovr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fab_int_sched #(.N_SRC(4), .SRC_W(2), .HOLDOFF_CYC(8), .ACK_TIMEOUT(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_en(src_en),
        .int_ack(int_ack), .clr_overrun(clr_overrun), .FAB_INT_OUT(d_out),
        .int_src(d_src), .int_busy(d_busy), .pending(d_pend), .overrun(d_ovr),
        .timeout_err(d_terr)
    );

    fab_int_sched #(.N_SRC(4), .SRC_W(2), .HOLDOFF_CYC(0), .ACK_TIMEOUT(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_en(src_en),
        .int_ack(int_ack), .clr_overrun(clr_overrun), .FAB_INT_OUT(z_out),
        .int_src(z_src), .int_busy(z_busy), .pending(z_pend), .overrun(z_ovr),
        .timeout_err(z_terr)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic       ack;
        logic       clr;
        logic       out;
        logic [1:0] src;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] req, input logic [3:0] en, input logic ack,
                       input logic clr, input logic out, input logic [1:0] src,
                       input logic busy, input logic [3:0] pend, input logic [3:0] ovr);
        vec_t v;
        v.req = req; v.en = en; v.ack = ack; v.clr = clr; v.out = out;
        v.src = src; v.busy = busy; v.pend = pend; v.ovr = ovr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(input logic lvl, input int bound, output int n);
        n = 0;
        while (d_out !== lvl && n < bound) begin
            step();
            n++;
        end
        if (d_out !== lvl) n = -1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        src_req = 4'hF; src_en = 4'hF; int_ack = 1'b0; clr_overrun = 1'b0;
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_out"},  32'(d_out),  32'(0));
        chk({tag, ".rst_src"},  32'(d_src),  32'(0));
        chk({tag, ".rst_busy"}, 32'(d_busy), 32'(0));
        chk({tag, ".rst_ovr"},  32'(d_ovr),  32'(0));
        chk({tag, ".rst_terr"}, 32'(d_terr), 32'(0));
        step();
        step();
        reset_n = 1'b1;
        chk({tag, ".rel_pend"},  32'(d_pend), 32'(0));
        chk({tag, ".rel_zpend"}, 32'(z_pend), 32'(0));
        chk({tag, ".rel_zout"},  32'(z_out),  32'(0));
        src_req = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        reset_n = 1'b0; src_req = 4'h0; src_en = 4'hF; int_ack = 1'b0; clr_overrun = 1'b0;
        do_reset("t1");

        // Single grant of source 2, holdoff, ack in IDLE, masking, overrun handling
        add(4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0);
        add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 4'h0);
        add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 4'h0);
        add(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 7; i++)
            add(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0);
        add(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0);
        add(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0);
        add(4'h8, 4'h7, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0);
        add(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0);
        add(4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h1, 4'h0);
        add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'h2, 4'h0);
        add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'h2, 4'h2);
        add(4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h2, 4'h0);
        add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'h2, 4'h2);
        add(4'h2, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h2, 4'h2);
        add(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h2, 4'h0);
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'h2, 4'h0);

        foreach (vq[i]) begin
            src_req = vq[i].req; src_en = vq[i].en;
            int_ack = vq[i].ack; clr_overrun = vq[i].clr;
            step();
            chk($sformatf("vec%0d.out", i),  32'(d_out),  32'(vq[i].out));
            chk($sformatf("vec%0d.src", i),  32'(d_src),  32'(vq[i].src));
            chk($sformatf("vec%0d.busy", i), 32'(d_busy), 32'(vq[i].busy));
            chk($sformatf("vec%0d.pend", i), 32'(d_pend), 32'(vq[i].pend));
            chk($sformatf("vec%0d.ovr", i),  32'(d_ovr),  32'(vq[i].ovr));
            chk($sformatf("vec%0d.terr", i), 32'(d_terr), 32'(0));
        end
        src_req = 4'h0; src_en = 4'hF; int_ack = 1'b0; clr_overrun = 1'b0;

        // Source 1 left pending during ASSERT is granted after the holdoff
        wait_d(1'b1, 30, n);
        chk("post.gap", 32'(n), 32'(9));
        chk("post.src", 32'(d_src), 32'(1));
        chk("post.pend", 32'(d_pend), 32'(0));
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("post.ack_out", 32'(d_out), 32'(0));

        // Round-robin order 0,1,2,3 from one burst on all sources
        do_reset("t3");
        src_req = 4'hF; step(); src_req = 4'h0;
        chk("rr.pend", 32'(d_pend), 32'hF);
        for (int k = 0; k < 4; k++) begin
            wait_d(1'b1, 30, n);
            chk($sformatf("rr%0d.gap", k), 32'(n), (k == 0) ? 32'(1) : 32'(9));
            chk($sformatf("rr%0d.src", k), 32'(d_src), 32'(k));
            int_ack = 1'b1; step(); int_ack = 1'b0;
            chk($sformatf("rr%0d.ack_out", k), 32'(d_out), 32'(0));
        end

        // Zero-holdoff instance: back-to-back grant one cycle after ack
        do_reset("t5");
        src_req = 4'h5; step(); src_req = 4'h0;
        chk("z.pend", 32'(z_pend), 32'h5);
        step();
        chk("z.out0", 32'(z_out), 32'(1));
        chk("z.src0", 32'(z_src), 32'(0));
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("z.ack_out", 32'(z_out), 32'(0));
        chk("z.ack_busy", 32'(z_busy), 32'(0));
        step();
        chk("z.out2", 32'(z_out), 32'(1));
        chk("z.src2", 32'(z_src), 32'(2));
        chk("z.pend2", 32'(z_pend), 32'(0));
        #2 reset_n = 1'b0;
        #1;
        chk("z.midrst_out", 32'(z_out), 32'(0));
        chk("z.midrst_busy", 32'(z_busy), 32'(0));
        step();
        reset_n = 1'b1;

`ifdef FAB_INT_TIMEOUT_EN
        // Ack timeout: forced release, error pulse, retry of same source, ack wins on expiry cycle
        do_reset("t6");
        src_req = 4'h2; step(); src_req = 4'h0;
        step();
        chk("tmo.out", 32'(d_out), 32'(1));
        chk("tmo.src", 32'(d_src), 32'(1));
        wait_d(1'b0, 40, n);
        chk("tmo.high_cycles", 32'(n), 32'(16));
        chk("tmo.err", 32'(d_terr), 32'(1));
        chk("tmo.retry_pend", 32'(d_pend), 32'h2);
        step();
        chk("tmo.err_pulse", 32'(d_terr), 32'(0));
        wait_d(1'b1, 40, n);
        chk("tmo.regap", 32'(n), 32'(8));
        chk("tmo.resrc", 32'(d_src), 32'(1));
        repeat (15) step();
        chk("tmo.still_high", 32'(d_out), 32'(1));
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("tmo.ackwin_out", 32'(d_out), 32'(0));
        chk("tmo.ackwin_err", 32'(d_terr), 32'(0));
        chk("tmo.ackwin_pend", 32'(d_pend), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
